// File: rtl/seq_pkg.sv
// Shared types and constants for the valve step sequencer.
// SEQ_PAUSE_EN adds the PAUSE state to the state enum.
package seq_pkg;

    localparam logic [2:0] UNIT_MS  = 3'b001;
    localparam logic [2:0] UNIT_S   = 3'b010;
    localparam logic [2:0] UNIT_MIN = 3'b011;
    localparam logic [2:0] UNIT_H   = 3'b100;
    localparam logic [2:0] UNIT_DAY = 3'b101;

    // One full 50 Hz period at 100 MHz so the slow counter sees the clear
    localparam int CLR_CYCLES_DEF = 2000000;

    localparam int STEP_VALVES  = 8;
    localparam int STEP_DELAY_W = 10;
    localparam int STEP_UNIT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ARM,
        S_WAIT,
        S_NEXT,
        S_DONE
`ifdef SEQ_PAUSE_EN
        , S_PAUSE
`endif
    } state_t;

    typedef struct packed {
        logic [STEP_VALVES-1:0]  valves;
        logic [STEP_DELAY_W-1:0] delay;
        logic [STEP_UNIT_W-1:0]  unit;
    } step_t;

endpackage

// File: rtl/seq_prog_ram.sv
// Step program store: one synchronous write port, one registered read port.
module seq_prog_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 21,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/valve_step_sequencer.sv
// Steps through a stored valve program, clearing/arming the delay counter per step.
// Optional macro SEQ_PAUSE_EN adds pause/paused and a PAUSE state after each step.
module valve_step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS  = 16,
    parameter int VALVES     = STEP_VALVES,
    parameter int DELAY_W    = STEP_DELAY_W,
    parameter int UNIT_W     = STEP_UNIT_W,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    localparam int AW = $clog2(NUM_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [VALVES-1:0]  prog_valves,
    input  logic [DELAY_W-1:0] prog_delay,
    input  logic [UNIT_W-1:0]  prog_unit,
    input  logic [AW-1:0]      last_step,
    input  logic               loop_en,
    input  logic               run,
    input  logic               abort,
    input  logic               count_done,
`ifdef SEQ_PAUSE_EN
    input  logic               pause,
    output logic               paused,
`endif
    output logic [VALVES-1:0]  valve_out,
    output logic [DELAY_W-1:0] delay,
    output logic [UNIT_W-1:0]  delay_unit,
    output logic               cnt_rst,
    output logic               cnt_start,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               seq_done
);

    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    typedef struct packed {
        logic [VALVES-1:0]  valves;
        logic [DELAY_W-1:0] delay;
        logic [UNIT_W-1:0]  unit;
    } step_rec_t;

    state_t        state, state_nxt, adv;
    step_rec_t     rd, wr;
    logic [AW-1:0] step_nxt, last_q;
    logic [CW-1:0] clr_cnt;
    logic          run_q, run_rise;
    logic          done_s1, done_s2, done_q, done_rise;
    logic          last_hit, step_ok, decide;

    assign wr = '{valves: prog_valves, delay: prog_delay, unit: prog_unit};

    // Read address follows the next step so data is ready on entry to LOAD
    seq_prog_ram #(
        .DEPTH (NUM_STEPS),
        .WIDTH (VALVES + DELAY_W + UNIT_W)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (wr),
        .raddr (step_nxt),
        .rdata (rd)
    );

    assign run_rise  = run && !run_q;
    assign done_rise = done_s2 && !done_q;
    assign last_hit  = (step_idx == last_q);
    assign step_ok   = (rd.unit >= UNIT_W'(UNIT_MS)) && (rd.unit <= UNIT_W'(UNIT_DAY))
                       && (rd.delay != '0);
`ifdef SEQ_PAUSE_EN
    assign decide = (state == S_NEXT) || (state == S_PAUSE);
    assign paused = (state == S_PAUSE);
`else
    assign decide = (state == S_NEXT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        adv = (last_hit && !loop_en) ? S_DONE : S_LOAD;
        case (state)
            S_IDLE:  if (run_rise) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = step_ok ? S_CLEAR : S_NEXT;
            S_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT:  if (done_rise) state_nxt = S_NEXT;
            S_NEXT: begin
`ifdef SEQ_PAUSE_EN
                if (pause) state_nxt = S_PAUSE;
                else
`endif
                state_nxt = adv;
            end
`ifdef SEQ_PAUSE_EN
            S_PAUSE: if (!pause) state_nxt = adv;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        cnt_rst   = 1'b1;
        cnt_start = 1'b0;
        busy      = 1'b1;
        seq_done  = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_ARM, S_WAIT: begin
                cnt_rst   = 1'b0;
                cnt_start = 1'b1;
            end
            S_DONE: begin
                busy     = 1'b0;
                seq_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        step_nxt = step_idx;
        if (state == S_IDLE && run_rise)
            step_nxt = '0;
        else if (decide && state_nxt == S_LOAD)
            step_nxt = last_hit ? '0 : step_idx + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            done_s1    <= 1'b0;
            done_s2    <= 1'b0;
            done_q     <= 1'b0;
            step_idx   <= '0;
            last_q     <= '0;
            clr_cnt    <= '0;
            valve_out  <= '0;
            delay      <= '0;
            delay_unit <= '0;
        end else begin
            run_q   <= run;
            done_s1 <= count_done;
            done_s2 <= done_s1;
            // Forcing the history high in ARM demands a fresh 0->1 edge
            done_q  <= (state == S_ARM) ? 1'b1 : done_s2;
            step_idx <= step_nxt;
            clr_cnt  <= (state == S_CLEAR) ? clr_cnt + CW'(1) : '0;
            if (state == S_IDLE && run_rise) last_q <= last_step;
            if (state_nxt == S_IDLE || state_nxt == S_DONE)
                valve_out <= '0;
            else if (state == S_LOAD)
                valve_out <= rd.valves;
            if (state == S_LOAD) begin
                delay      <= rd.delay;
                delay_unit <= rd.unit;
            end
        end
    end

endmodule

// File: tb/tb_valve_step_sequencer.sv
// Directed bench for valve_step_sequencer with a small counter model driving count_done.
// Build with SEQ_PAUSE_EN to also exercise the pause scenario.
module tb_valve_step_sequencer;

    localparam int DONE_AFTER = 3;

    logic       clk = 1'b0;
    logic       rst, prog_we, loop_en, run, abort, count_done;
    logic [3:0] prog_addr, last_step, step_idx;
    logic [7:0] prog_valves, valve_out;
    logic [9:0] prog_delay, delay;
    logic [2:0] prog_unit, delay_unit;
    logic       cnt_rst, cnt_start, busy, seq_done;
`ifdef SEQ_PAUSE_EN
    logic       pause, paused;
`endif

    int   asserts = 0;
    int   fails = 0;
    int   cd_cnt = 0;
    logic model_en = 1'b1;

    valve_step_sequencer #(.NUM_STEPS(16), .VALVES(8), .DELAY_W(10), .UNIT_W(3), .CLR_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_valves(prog_valves), .prog_delay(prog_delay), .prog_unit(prog_unit),
        .last_step(last_step), .loop_en(loop_en), .run(run), .abort(abort),
        .count_done(count_done),
`ifdef SEQ_PAUSE_EN
        .pause(pause), .paused(paused),
`endif
        .valve_out(valve_out), .delay(delay), .delay_unit(delay_unit),
        .cnt_rst(cnt_rst), .cnt_start(cnt_start), .step_idx(step_idx),
        .busy(busy), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    // Counter stand-in: count_done rises DONE_AFTER cycles into cnt_start, clears on cnt_rst
    task automatic tick();
        @(posedge clk); #1;
        if (cnt_rst) begin
            cd_cnt = 0;
            count_done = 1'b0;
        end else if (cnt_start && model_en) begin
            cd_cnt++;
            if (cd_cnt == DONE_AFTER) count_done = 1'b1;
        end
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] v, input logic [9:0] d, input logic [2:0] u);
        prog_we = 1'b1; prog_addr = a; prog_valves = v; prog_delay = d; prog_unit = u;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        asserts++;
        if ({valve_out, delay, delay_unit, cnt_rst, cnt_start, step_idx, busy, seq_done} !== {8'h0, 10'h0, 3'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_hold: got v=%h d=%h u=%h rst=%b st=%b idx=%h busy=%b", valve_out, delay, delay_unit, cnt_rst, cnt_start, step_idx, busy);
        end
        rst = 1'b1;
        tick(); tick();
        asserts++;
        if ({valve_out, cnt_rst, cnt_start, step_idx, busy, seq_done} !== {8'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_idle: got v=%h rst=%b st=%b idx=%h busy=%b sd=%b exp 00 1 0 0 0 0", valve_out, cnt_rst, cnt_start, step_idx, busy, seq_done);
        end
    endtask

    task automatic test_program();
        logic [7:0] ev [3] = '{8'h01, 8'h82, 8'h00};
        logic [9:0] ed [3] = '{10'd5, 10'd2, 10'd1};
        logic [2:0] eu [3] = '{3'b001, 3'b010, 3'b001};
        int n = 0, rl = 0, sd = 0;
        logic ps = 1'b0, fin = 1'b0;
        prog(0, 8'h01, 10'd5, 3'b001);
        prog(1, 8'h82, 10'd2, 3'b010);
        prog(2, 8'h00, 10'd1, 3'b001);
        last_step = 4'd2; loop_en = 1'b0; model_en = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            tick(); run = 1'b0;
            if (cnt_start && !ps && n < 3) begin
                asserts++;
                if ({valve_out, delay, delay_unit} !== {ev[n], ed[n], eu[n]}) begin
                    fails++; $display("FAIL prog_step%0d: got v=%h d=%0d u=%b exp v=%h d=%0d u=%b", n, valve_out, delay, delay_unit, ev[n], ed[n], eu[n]);
                end
                asserts++;
                if (rl !== ((n == 0) ? 5 : 6)) begin
                    fails++; $display("FAIL prog_clear_len%0d: got %0d exp %0d", n, rl, (n == 0) ? 5 : 6);
                end
                n++;
            end
            ps = cnt_start;
            rl = (busy && cnt_rst) ? rl + 1 : 0;
            if (seq_done) begin
                sd++; fin = 1'b1;
                asserts++;
                if ({busy, valve_out} !== 9'h0) begin
                    fails++; $display("FAIL prog_done_state: got busy=%b v=%h exp 0 00", busy, valve_out);
                end
            end
        end
        asserts++;
        if (!fin) begin fails++; $display("FAIL prog_timeout: seq_done not seen, exp within 400 cycles"); end
        repeat (3) begin tick(); if (seq_done) sd++; end
        asserts++;
        if ({n, sd, busy} !== {32'd3, 32'd1, 1'b0}) begin
            fails++; $display("FAIL prog_summary: got steps=%0d done_pulses=%0d busy=%b exp 3 1 0", n, sd, busy);
        end
    endtask

    task automatic test_skip();
        logic [3:0] eidx [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
        logic [7:0] ev   [8] = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h00, 8'h00};
        logic [1:0] ebd  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        prog(0, 8'h11, 10'd0, 3'b001);
        prog(1, 8'h22, 10'd3, 3'b000);
        prog(2, 8'h33, 10'd7, 3'b110);
        last_step = 4'd2; loop_en = 1'b0; model_en = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(); run = 1'b0;
            asserts++;
            if ({step_idx, valve_out, busy, seq_done, cnt_start, cnt_rst} !== {eidx[c], ev[c], ebd[c], 1'b0, 1'b1}) begin
                fails++; $display("FAIL skip_cycle%0d: got idx=%h v=%h busy=%b sd=%b st=%b rst=%b exp idx=%h v=%h busy/sd=%b st=0 rst=1",
                                  c, step_idx, valve_out, busy, seq_done, cnt_start, cnt_rst, eidx[c], ev[c], ebd[c]);
            end
        end
        model_en = 1'b1;
    endtask

    task automatic test_loop_abort();
        logic [3:0] eidx [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [7:0] ev   [4] = '{8'h05, 8'h0A, 8'h05, 8'h0A};
        int n = 0, sd = 0;
        logic ps = 1'b0;
        prog(0, 8'h05, 10'd1, 3'b001);
        prog(1, 8'h0A, 10'd1, 3'b001);
        last_step = 4'd1; loop_en = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 400 && n < 4; c++) begin
            tick(); run = 1'b0;
            if (seq_done) sd++;
            if (cnt_start && !ps) begin
                asserts++;
                if ({step_idx, valve_out} !== {eidx[n], ev[n]}) begin
                    fails++; $display("FAIL loop_step%0d: got idx=%h v=%h exp idx=%h v=%h", n, step_idx, valve_out, eidx[n], ev[n]);
                end
                n++;
            end
            ps = cnt_start;
        end
        asserts++;
        if ({n, sd} !== {32'd4, 32'd0}) begin
            fails++; $display("FAIL loop_progress: got arms=%0d done_pulses=%0d exp 4 0", n, sd);
        end
        abort = 1'b1;
        tick(); abort = 1'b0;
        asserts++;
        if ({busy, valve_out, cnt_rst, cnt_start, seq_done} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL abort_idle: got busy=%b v=%h rst=%b st=%b sd=%b exp 0 00 1 0 0", busy, valve_out, cnt_rst, cnt_start, seq_done);
        end
        loop_en = 1'b0;
        run = 1'b1; abort = 1'b1;
        tick(); run = 1'b0; abort = 1'b0;
        tick();
        asserts++;
        if ({busy, seq_done} !== 2'b00) begin
            fails++; $display("FAIL run_abort_same_cycle: got busy=%b sd=%b exp 0 0", busy, seq_done);
        end
    endtask

    task automatic test_busy_lockout();
        int sd = 0;
        logic hit = 1'b0;
        prog(0, 8'h3C, 10'd2, 3'b001);
        last_step = 4'd0; loop_en = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 50 && !cnt_start; c++) begin tick(); run = 1'b0; end
        prog_we = 1'b1; prog_addr = 4'd0; prog_valves = 8'hFF; prog_delay = 10'd9; prog_unit = 3'b010;
        run = 1'b1;
        tick();
        prog_we = 1'b0; run = 1'b0;
        asserts++;
        if ({busy, step_idx, cnt_start} !== {1'b1, 4'd0, 1'b1}) begin
            fails++; $display("FAIL lock_run_ignored: got busy=%b idx=%h st=%b exp 1 0 1", busy, step_idx, cnt_start);
        end
        for (int c = 0; c < 100 && sd == 0; c++) begin tick(); if (seq_done) sd++; end
        repeat (5) begin tick(); if (seq_done) sd++; end
        asserts++;
        if ({sd, busy} !== {32'd1, 1'b0}) begin
            fails++; $display("FAIL lock_no_restart: got done_pulses=%0d busy=%b exp 1 0", sd, busy);
        end
        run = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin tick(); run = 1'b0; hit = cnt_start; end
        asserts++;
        if ({hit, valve_out, delay, delay_unit} !== {1'b1, 8'h3C, 10'd2, 3'b001}) begin
            fails++; $display("FAIL lock_ram_unchanged: got armed=%b v=%h d=%0d u=%b exp 1 3c 2 001", hit, valve_out, delay, delay_unit);
        end
        for (int c = 0; c < 100 && busy; c++) tick();
    endtask

    task automatic test_reset_mid_wait();
        logic hit = 1'b0;
        prog(0, 8'h01, 10'd0, 3'b001);
        prog(1, 8'h02, 10'd0, 3'b001);
        prog(2, 8'h77, 10'd4, 3'b001);
        last_step = 4'd2; loop_en = 1'b0; model_en = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin tick(); run = 1'b0; hit = cnt_start; end
        tick(); tick();
        asserts++;
        if ({cnt_start, step_idx, valve_out} !== {1'b1, 4'd2, 8'h77}) begin
            fails++; $display("FAIL wait_before_reset: got st=%b idx=%h v=%h exp 1 2 77", cnt_start, step_idx, valve_out);
        end
        rst = 1'b0;
        tick();
        asserts++;
        if ({valve_out, cnt_rst, busy, step_idx, cnt_start, seq_done} !== {8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_mid_wait: got v=%h rst=%b busy=%b idx=%h st=%b sd=%b exp 00 1 0 0 0 0",
                              valve_out, cnt_rst, busy, step_idx, cnt_start, seq_done);
        end
        rst = 1'b1; model_en = 1'b1;
        tick();
    endtask

`ifdef SEQ_PAUSE_EN
    task automatic test_pause();
        logic hit = 1'b0;
        logic fin = 1'b0;
        prog(0, 8'h01, 10'd2, 3'b001);
        prog(1, 8'h02, 10'd2, 3'b001);
        last_step = 4'd1; loop_en = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 50 && !cnt_start; c++) begin tick(); run = 1'b0; end
        pause = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin tick(); hit = paused; end
        repeat (3) tick();
        asserts++;
        if ({paused, valve_out, cnt_rst, step_idx, busy} !== {1'b1, 8'h01, 1'b1, 4'd0, 1'b1}) begin
            fails++; $display("FAIL pause_hold: got paused=%b v=%h rst=%b idx=%h busy=%b exp 1 01 1 0 1", paused, valve_out, cnt_rst, step_idx, busy);
        end
        pause = 1'b0;
        tick();
        asserts++;
        if ({paused, step_idx, busy, cnt_start} !== {1'b0, 4'd1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL pause_resume: got paused=%b idx=%h busy=%b st=%b exp 0 1 1 0", paused, step_idx, busy, cnt_start);
        end
        for (int c = 0; c < 100 && !fin; c++) begin tick(); fin = seq_done; end
        asserts++;
        if (!fin) begin fails++; $display("FAIL pause_finish: seq_done not seen, exp within 100 cycles"); end
    endtask
`endif

    initial begin
        rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_valves = '0; prog_delay = '0; prog_unit = '0;
        last_step = '0; loop_en = 1'b0; run = 1'b0; abort = 1'b0; count_done = 1'b0;
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        tick(); tick();
        test_reset();
        test_program();
        test_skip();
        test_loop_abort();
        test_busy_lockout();
        test_reset_mid_wait();
`ifdef SEQ_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, exp completion before 500000");
        $fatal(1, "watchdog");
    end

endmodule
